// File: rtl/ysyx_22050133_issue_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22050133_issue_ctrl_pkg
// Description : Shared ysyx_22050133 defines: ALU op, control and md FSM codes.
// Revision    : 1.0 - initial release
// ============================================================================
package ysyx_22050133_issue_ctrl_pkg;

   localparam int C_NREG = 32;
   localparam int C_RW   = 5;

   localparam logic [3:0] C_ALU_ADD = 4'd0;
   localparam logic [3:0] C_ALU_SUB = 4'd1;
   localparam logic [3:0] C_ALU_MUL = 4'd8;
   localparam logic [3:0] C_ALU_DIV = 4'd9;
   localparam logic [3:0] C_ALU_REM = 4'd10;

   localparam logic [1:0] C_CTRL_WB_ALU = 2'd0;
   localparam logic [1:0] C_CTRL_WB_MEM = 2'd1;
   localparam logic [1:0] C_CTRL_WB_MD  = 2'd2;

   localparam logic [1:0] C_MD_IDLE = 2'd0;
   localparam logic [1:0] C_MD_BUSY = 2'd1;
   localparam logic [1:0] C_MD_DONE = 2'd2;

   // x0 never becomes pending, so its bit is stripped from every decode.
   function automatic logic [C_NREG-1:0] reg_bit(input logic [C_RW-1:0] r);
      logic [C_NREG-1:0] v;
      v    = {{(C_NREG-1){1'b0}}, 1'b1} << r;
      v[0] = 1'b0;
      return v;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_22050133_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22050133_scoreboard
// Description : Per-register pending bits with set/two-clear ports and hazard compare.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_22050133_scoreboard
   import ysyx_22050133_issue_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              set_en,
   input  logic [C_RW-1:0]   set_rd,
   input  logic              clr_a_en,
   input  logic [C_RW-1:0]   clr_a_rd,
   input  logic              clr_b_en,
   input  logic [C_RW-1:0]   clr_b_rd,
   input  logic [C_RW-1:0]   rs1,
   input  logic [C_RW-1:0]   rs2,
   input  logic [C_RW-1:0]   rd,
   input  logic              rdwen,
   output logic              hazard,
   output logic [C_NREG-1:0] busy_mask
);

   logic [C_NREG-1:0] r_pending;
   logic [C_NREG-1:0] w_set;
   logic [C_NREG-1:0] w_clr_a;
   logic [C_NREG-1:0] w_clr_b;

   assign w_set   = set_en   ? reg_bit(set_rd)   : '0;
   assign w_clr_a = clr_a_en ? reg_bit(clr_a_rd) : '0;
   assign w_clr_b = clr_b_en ? reg_bit(clr_b_rd) : '0;

   // Set is applied after both clears so an issue wins over a same-cycle writeback.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pending <= '0;
      end else begin
         r_pending <= (r_pending & ~w_clr_a & ~w_clr_b) | w_set;
      end
   end

   assign hazard = ((rs1 != '0) && r_pending[rs1])
                 | ((rs2 != '0) && r_pending[rs2])
                 | (rdwen && (rd != '0) && r_pending[rd]);

   assign busy_mask = r_pending;

endmodule
`default_nettype wire

// File: rtl/ysyx_22050133_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22050133_issue_ctrl
// Description : Issue gating with register scoreboard and mul/div sequencing FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_22050133_issue_ctrl
   import ysyx_22050133_issue_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [C_RW-1:0]   id_rs1,
   input  logic [C_RW-1:0]   id_rs2,
   input  logic [C_RW-1:0]   id_rd,
   input  logic              id_rdwen,
   input  logic              id_is_md,
   output logic              id_ready,
   input  logic              wb_valid,
   input  logic [C_RW-1:0]   wb_rd,
   output logic              md_start,
   input  logic              md_done,
   output logic              md_wb_valid,
   input  logic              md_wb_ready,
   output logic [C_RW-1:0]   md_rd,
   output logic [C_NREG-1:0] busy_mask,
   output logic [1:0]        md_state
);

   logic            w_hazard;
   logic            w_issue;
   logic            w_md_issue;
   logic            w_md_hs;
   logic            w_set_en;
   logic [1:0]      w_state_nxt;
   logic [1:0]      r_state;
   logic            r_md_start;
   logic [C_RW-1:0] r_md_rd;
   logic            r_md_wen;

   // Only registered state and id_* feed id_ready; wb/md clears act next cycle.
   assign id_ready   = ~w_hazard & ~(id_is_md & (r_state != C_MD_IDLE));
   assign w_issue    = id_valid & id_ready;
   assign w_md_issue = w_issue & id_is_md;
   assign w_md_hs    = (r_state == C_MD_DONE) & md_wb_ready;
   assign w_set_en   = w_issue & id_rdwen & (id_rd != '0);

   ysyx_22050133_scoreboard u_scoreboard (
      .clk       (clk),
      .rst       (rst),
      .set_en    (w_set_en),
      .set_rd    (id_rd),
      .clr_a_en  (wb_valid),
      .clr_a_rd  (wb_rd),
      .clr_b_en  (w_md_hs & r_md_wen),
      .clr_b_rd  (r_md_rd),
      .rs1       (id_rs1),
      .rs2       (id_rs2),
      .rd        (id_rd),
      .rdwen     (id_rdwen),
      .hazard    (w_hazard),
      .busy_mask (busy_mask)
   );

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         C_MD_IDLE: if (w_md_issue) w_state_nxt = C_MD_BUSY;
         C_MD_BUSY: if (md_done)    w_state_nxt = C_MD_DONE;
         C_MD_DONE: if (w_md_hs)    w_state_nxt = C_MD_IDLE;
         default:                   w_state_nxt = C_MD_IDLE;
      endcase
   end

   // r_md_wen keeps a non-writing md op from clearing another instruction's bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= C_MD_IDLE;
         r_md_start <= 1'b0;
         r_md_rd    <= '0;
         r_md_wen   <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_md_start <= w_md_issue;
         if (w_md_issue) begin
            r_md_rd  <= id_rd;
            r_md_wen <= id_rdwen & (id_rd != '0);
         end
      end
   end

   assign md_start    = r_md_start;
   assign md_wb_valid = (r_state == C_MD_DONE);
   assign md_rd       = r_md_rd;
   assign md_state    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22050133_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ysyx_22050133_issue_ctrl
// Description : Directed scoreboard bench for the issue controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_22050133_issue_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        id_valid;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic        id_rdwen, id_is_md;
   logic        id_ready;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic        md_start;
   logic        md_done;
   logic        md_wb_valid;
   logic        md_wb_ready;
   logic [4:0]  md_rd;
   logic [31:0] busy_mask;
   logic [1:0]  md_state;

   typedef struct {
      int          cyc;
      int          sid;
      logic        rdy;
      logic [31:0] busy;
      logic [1:0]  st;
      logic        start;
      logic        wbv;
   } exp_t;

   exp_t       exp_q[$];
   logic [4:0] md_q[$];
   logic [4:0] wb_q[$];
   int         cyc_cnt = 0;
   int         sid = 0;
   int         total = 0;
   int         bad = 0;

   ysyx_22050133_issue_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .id_valid    (id_valid),
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .id_rd       (id_rd),
      .id_rdwen    (id_rdwen),
      .id_is_md    (id_is_md),
      .id_ready    (id_ready),
      .wb_valid    (wb_valid),
      .wb_rd       (wb_rd),
      .md_start    (md_start),
      .md_done     (md_done),
      .md_wb_valid (md_wb_valid),
      .md_wb_ready (md_wb_ready),
      .md_rd       (md_rd),
      .busy_mask   (busy_mask),
      .md_state    (md_state)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   task automatic check(input string name, input int step, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s step=%0d got=%0h expected=%0h", name, step, act, exp);
      end
   endtask

   // Monitor: per-cycle expectations plus event-driven md_start / md writeback checks.
   always @(negedge clk) begin
      exp_t e;
      logic [4:0] r;
      while (exp_q.size() > 0 && exp_q[0].cyc == cyc_cnt) begin
         e = exp_q.pop_front();
         check("id_ready",    e.sid, {31'd0, id_ready},    {31'd0, e.rdy});
         check("busy_mask",   e.sid, busy_mask,            e.busy);
         check("md_state",    e.sid, {30'd0, md_state},    {30'd0, e.st});
         check("md_start",    e.sid, {31'd0, md_start},    {31'd0, e.start});
         check("md_wb_valid", e.sid, {31'd0, md_wb_valid}, {31'd0, e.wbv});
      end
      if (md_start === 1'b1) begin
         if (md_q.size() == 0) check("md_start_unexpected", cyc_cnt, 32'd1, 32'd0);
         else begin
            r = md_q.pop_front();
            check("md_rd_at_start", cyc_cnt, {27'd0, md_rd}, {27'd0, r});
         end
      end
      if (md_wb_valid === 1'b1 && md_wb_ready === 1'b1) begin
         if (wb_q.size() == 0) check("md_wb_unexpected", cyc_cnt, 32'd1, 32'd0);
         else begin
            r = wb_q.pop_front();
            check("md_rd_at_wb", cyc_cnt, {27'd0, md_rd}, {27'd0, r});
         end
      end
   end

   task automatic step(input logic rdy, input logic [31:0] busy, input logic [1:0] st, input logic start);
      exp_t e;
      e.cyc = cyc_cnt; e.sid = sid; e.rdy = rdy; e.busy = busy;
      e.st = st; e.start = start; e.wbv = (st == 2'd2);
      exp_q.push_back(e);
      sid++;
      @(posedge clk);
      #1;
   endtask

   task automatic id(input logic v, input logic [4:0] s1, input logic [4:0] s2,
                     input logic [4:0] d, input logic wen, input logic md);
      id_valid = v; id_rs1 = s1; id_rs2 = s2; id_rd = d; id_rdwen = wen; id_is_md = md;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; wb_valid = 1'b0; wb_rd = '0; md_done = 1'b0; md_wb_ready = 1'b0;
      id(0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      step(1, 32'h0, 0, 0);
      // RAW stall on x5
      id(1, 0, 0, 5, 1, 0);                 step(1, 32'h0,  0, 0);
      id(1, 5, 0, 0, 0, 0);                 step(0, 32'h20, 0, 0);
      wb_valid = 1; wb_rd = 5;              step(0, 32'h20, 0, 0);
      wb_valid = 0;                         step(1, 32'h0,  0, 0);
      // x0 never pending
      id(1, 0, 0, 0, 1, 0);                 step(1, 32'h0, 0, 0);
      wb_valid = 1; wb_rd = 0;              step(1, 32'h0, 0, 0);
      wb_valid = 0; id(0, 0, 0, 0, 0, 0);   step(1, 32'h0, 0, 0);
      // WAW on x12
      id(1, 0, 0, 12, 1, 0);                step(1, 32'h0,    0, 0);
                                            step(0, 32'h1000, 0, 0);
      id(1, 0, 0, 12, 0, 0);                step(1, 32'h1000, 0, 0);
      id(1, 0, 0, 12, 1, 0); wb_valid = 1; wb_rd = 12;
                                            step(0, 32'h1000, 0, 0);
      wb_valid = 0; id(0, 0, 0, 12, 1, 0);  step(1, 32'h0,    0, 0);
      // set wins over same-cycle clear
      id(1, 0, 0, 4, 1, 0); wb_valid = 1; wb_rd = 4;
                                            step(1, 32'h0,  0, 0);
      id(0, 0, 0, 0, 0, 0);                 step(1, 32'h10, 0, 0);
      wb_valid = 0;                         step(1, 32'h0,  0, 0);
      // mul/div with rd=7 and delayed write port
      id(1, 0, 0, 7, 1, 1); md_q.push_back(5'd7);
                                            step(1, 32'h0,  0, 0);
      id(1, 0, 0, 8, 1, 1);                 step(0, 32'h80, 1, 1);
                                            step(0, 32'h80, 1, 0);
      md_done = 1;                          step(0, 32'h80, 1, 0);
      md_done = 0; id(0, 0, 0, 8, 1, 1);    step(0, 32'h80, 2, 0);
      md_done = 1;                          step(0, 32'h80, 2, 0);
      md_done = 0;                          step(0, 32'h80, 2, 0);
      md_wb_ready = 1; wb_q.push_back(5'd7);
                                            step(0, 32'h80, 2, 0);
      // back-to-back md issue right after DONE->IDLE
      md_wb_ready = 0; id(1, 0, 0, 9, 1, 1); md_q.push_back(5'd9);
                                            step(1, 32'h0,   0, 0);
      id(1, 0, 0, 3, 1, 0);                 step(1, 32'h200, 1, 1);
      id(0, 0, 0, 0, 0, 0); md_done = 1;    step(1, 32'h208, 1, 0);
      md_done = 0; md_wb_ready = 1; wb_valid = 1; wb_rd = 3; wb_q.push_back(5'd9);
                                            step(1, 32'h208, 2, 0);
      md_wb_ready = 0; wb_valid = 0;        step(1, 32'h0,   0, 0);
      // reset while BUSY, stale md_done afterwards
      id(1, 0, 0, 10, 1, 1); md_q.push_back(5'd10);
                                            step(1, 32'h0,   0, 0);
      id(0, 0, 0, 0, 0, 0); rst = 1;        step(1, 32'h400, 1, 1);
      rst = 0; md_done = 1;                 step(1, 32'h0,   0, 0);
      md_done = 0;                          step(1, 32'h0,   0, 0);
      // non-writing md op sequences without a pending bit
      id(1, 0, 0, 6, 0, 1); md_q.push_back(5'd6);
                                            step(1, 32'h0, 0, 0);
      id(0, 0, 0, 0, 0, 0); md_done = 1;    step(1, 32'h0, 1, 1);
      md_done = 0; md_wb_ready = 1; wb_q.push_back(5'd6);
                                            step(1, 32'h0, 2, 0);
      md_wb_ready = 0;                      step(1, 32'h0, 0, 0);

      repeat (2) @(posedge clk);
      #1;
      check("exp_q_drained", 0, exp_q.size(), 0);
      check("md_q_drained",  0, md_q.size(),  0);
      check("wb_q_drained",  0, wb_q.size(),  0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
